// File: rtl/mips_fetch_pkg.sv
// Shared types, default vectors and PC arithmetic for the MIPS fetch front end.
package mips_fetch_pkg;

  // Fetch FSM: FETCH issues, WAIT holds a live request, DRAIN holds a stale one.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

  // Sequential PC step: the low field wraps, the kernel bit (addr_w-1) is preserved.
  // Operates on a 64-bit container so any address width up to 64 can use it.
  function automatic logic [63:0] pc_inc(input logic [63:0] pc, input int addr_w);
    logic [63:0] kbit;
    logic [63:0] low_mask;
    kbit     = 64'd1 << (addr_w - 1);
    low_mask = kbit - 64'd1;
    return (pc & kbit) | ((pc + 64'd4) & low_mask);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop/flush, exposes head, the entry behind it, and count.
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  parameter int PEEK_W = WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [WIDTH-1:0]          head_data,
  output logic [PEEK_W-1:0]         next_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;
  logic             do_push;
  logic [WIDTH-1:0] next_entry;

  // Pop only a real entry; push when space exists or the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head and next-entry read ports.
  always_comb begin
    head_data  = mem_q[rd_ptr_q];
    next_entry = mem_q[rd_ptr_q + PW'(1)];
    next_data  = next_entry[PEEK_W-1:0];
    count      = count_q;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: PC, single-outstanding imem requester, prefetch
// FIFO, and exception/interrupt/redirect vectoring with EPC capture.
//
// Handshakes: dec_valid/dec_ready transfer the FIFO head on any cycle where both are 1;
// dec_valid never depends on dec_ready. imem_req, once raised, stays high with
// imem_addr stable until the cycle imem_ack is seen (ack is a one-cycle pulse carrying
// imem_rdata in that cycle).
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] IRQ_VEC    = ADDR_W'(DEF_IRQ_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              irq,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic [ADDR_W-1:0] epc,
  output logic              kernel_mode,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 32 + ADDR_W;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [FW-1:0]     head_data;
  logic [ADDR_W-1:0] next_pc;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_flush;
  logic              pop;
  logic              in_flight;
  logic              slots_free;
  logic              issue;
  logic              irq_take;
  logic              any_event;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] irq_epc;

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (FW),
    .PEEK_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({imem_rdata, addr_q}),
    .pop       (pop),
    .flush     (fifo_flush),
    .head_data (head_data),
    .next_data (next_pc),
    .count     (count)
  );

  // Event decode, request issue and decode-side outputs.
  always_comb begin
    kernel_mode    = pc_q[ADDR_W-1];
    fifo_empty     = (count == '0);
    dec_valid      = !fifo_empty;
    dec_inst       = dec_valid ? head_data[FW-1:ADDR_W] : 32'd0;
    dec_pc         = dec_valid ? head_data[ADDR_W-1:0]  : '0;
    pop            = dec_valid && dec_ready;
    in_flight      = (state_q != FETCH);
    // IRQ is held off in kernel mode and yields to exceptions and redirects.
    irq_take       = irq && !kernel_mode && !exc_valid && !redirect_valid;
    any_event      = exc_valid || irq_take || redirect_valid;
    slots_free     = ({1'b0, count} + {{CW{1'b0}}, in_flight}) < (CW + 1)'(FIFO_DEPTH);
    // No new request in an event cycle: the PC is about to change.
    issue          = reset && (state_q == FETCH) && slots_free && !any_event;
    imem_req       = issue || (reset && in_flight);
    imem_addr      = (state_q == FETCH) ? pc_q : addr_q;
    fifo_push      = (state_q == WAIT) && imem_ack && !any_event;
    pc_plus        = ADDR_W'(pc_inc(64'(pc_q), ADDR_W));
    target_aligned = redirect_target & ~ADDR_W'(3);
    // Return address: the oldest word decode has not yet taken.
    if (!fifo_empty && !pop)          irq_epc = dec_pc;
    else if (pop && count >= CW'(2))  irq_epc = next_pc;
    else                              irq_epc = pc_q;
    epc            = epc_q;
    dbg_state      = state_q;
  end

  // Next-state logic: FSM sequencing, PC update, event vectoring and EPC capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_d     = addr_q;
    fifo_flush = 1'b0;
    if (issue) begin
      addr_d  = pc_q;
      state_d = WAIT;
    end
    case (state_q)
      WAIT: begin
        if (imem_ack) begin
          pc_d    = pc_plus;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = FETCH;
      end
      default: ;
    endcase
    if (any_event) begin
      fifo_flush = 1'b1;
      if (exc_valid) begin
        pc_d  = EXC_VEC;
        epc_d = exc_pc;
      end else if (irq_take) begin
        pc_d  = IRQ_VEC;
        epc_d = irq_epc;
      end else begin
        pc_d = target_aligned;
      end
      // A live request without its ack must still complete on the bus; its data is stale.
      state_d = (in_flight && !imem_ack) ? DRAIN : FETCH;
    end
  end

  // Architectural and FSM registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      addr_q  <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: behavioural instruction memory, decode-side scoreboard,
// and one task per scenario.
module tb_mips_fetch_unit;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        irq;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic [31:0] epc;
  logic        kernel_mode;
  logic [1:0]  dbg_state;

  int          errors;
  int          checks;
  int          cyc;
  int          base_cyc;
  int          ack_count;
  int          base_ack;
  int          mem_lat;
  bit          mem_rand;
  logic [63:0] exp_q[$];
  int          pop_cyc_q[$];

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .irq             (irq),
    .exc_valid       (exc_valid),
    .exc_pc          (exc_pc),
    .epc             (epc),
    .kernel_mode     (kernel_mode),
    .dbg_state       (dbg_state)
  );

  // Clock and free-running cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [63:0] exp_of(input logic [31:0] a);
    return {a, inst_of(a)};
  endfunction

  // Instruction memory: acks a held request cur_lat cycles after it is first seen.
  initial begin
    int wait_cnt;
    int cur_lat;
    wait_cnt   = 0;
    cur_lat    = 1;
    ack_count  = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack = 1'b0;
      if (imem_req === 1'b1) begin
        if (wait_cnt == 0) cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        if (wait_cnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = inst_of(imem_addr);
          ack_count  = ack_count + 1;
          wait_cnt   = 0;
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard and bus protocol monitor, sampled mid-cycle.
  initial begin
    logic        prev_rst;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [63:0] exp;
    prev_rst  = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
          pop_cyc_q.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got pc=%h inst=%h, none expected", dec_pc, dec_inst);
          end else begin
            exp = exp_q.pop_front();
            if ({dec_pc, dec_inst} !== exp) begin
              errors++;
              $display("FAIL dec_word: got pc=%h inst=%h want pc=%h inst=%h",
                       dec_pc, dec_inst, exp[63:32], exp[31:0]);
            end
          end
        end
        if (prev_rst === 1'b1 && prev_req === 1'b1 && prev_ack !== 1'b1) begin
          checks++;
          if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
            errors++;
            $display("FAIL req_hold: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
          end
        end
      end
      prev_rst  = reset;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    dec_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    irq             = 1'b0;
    exc_valid       = 1'b0;
    exc_pc          = 32'd0;
    mem_lat         = 1;
    mem_rand        = 1'b0;
    tick();
    tick();
    exp_q.delete();
    pop_cyc_q.delete();
    reset    = 1'b1;
    base_cyc = cyc;
    base_ack = ack_count;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0)       begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (dec_valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
    checks++; if (dec_pc !== 32'd0)        begin errors++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
    checks++; if (dec_inst !== 32'd0)      begin errors++; $display("FAIL reset_dec_inst: got %h want 0", dec_inst); end
    checks++; if (epc !== 32'd0)           begin errors++; $display("FAIL reset_epc: got %h want 0", epc); end
    checks++; if (kernel_mode !== 1'b1)    begin errors++; $display("FAIL reset_kernel: got %b want 1", kernel_mode); end
    checks++; if (dbg_state !== ST_FETCH)  begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=80000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_of(32'h8000_0000 + 32'(4 * i)));
    wait_empty("sequential", 40);
    dec_ready = 1'b0;
    checks++;
    if (pop_cyc_q.size() != 5 || pop_cyc_q[0] - base_cyc != 2) begin
      errors++;
      $display("FAIL seq_first_latency: got %0d pops first at cycle %0d want 5 pops first at cycle 2",
               pop_cyc_q.size(), (pop_cyc_q.size() > 0) ? pop_cyc_q[0] - base_cyc : -1);
    end
    for (int i = 1; i < 5; i++) begin
      if (i < pop_cyc_q.size()) begin
        checks++;
        if (pop_cyc_q[i] - pop_cyc_q[i-1] != 2) begin
          errors++;
          $display("FAIL seq_rate: got gap %0d want 2 before word %0d", pop_cyc_q[i] - pop_cyc_q[i-1], i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (20) tick();
    checks++; if (ack_count - base_ack != 4) begin errors++; $display("FAIL bp_acks: got %0d want 4", ack_count - base_ack); end
    checks++; if (imem_req !== 1'b0)         begin errors++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL bp_head: got valid=%b pc=%h want valid=1 pc=80000000", dec_valid, dec_pc);
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(exp_of(32'h8000_0000 + 32'(4 * i)));
    dec_ready = 1'b1;
    wait_empty("backpressure", 60);
    dec_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat   = 3;
    dec_ready = 1'b1;
    tick();
    checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rd_pre_state: got %0d want 1", dbg_state); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (dbg_state !== ST_DRAIN) begin errors++; $display("FAIL rd_drain_state: got %0d want 2", dbg_state); end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL rd_drain_hold: got req=%b addr=%h want req=1 addr=80000000", imem_req, imem_addr);
    end
    checks++; if (kernel_mode !== 1'b0) begin errors++; $display("FAIL rd_kernel: got %b want 0", kernel_mode); end
    exp_q.push_back(exp_of(32'h0000_0100));
    exp_q.push_back(exp_of(32'h0000_0104));
    wait_empty("redirect_wait", 40);
    dec_ready = 1'b0;
  endtask

  task automatic test_irq_epc();
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0038;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (dec_pc !== 32'h0000_0038 || imem_addr !== 32'h0000_0040 || kernel_mode !== 1'b0) begin
      errors++;
      $display("FAIL irq_setup: got head=%h pc=%h kernel=%b want head=38 pc=40 kernel=0",
               dec_pc, imem_addr, kernel_mode);
    end
    irq = 1'b1;
    tick();
    checks++; if (epc !== 32'h0000_0038) begin errors++; $display("FAIL irq_epc: got %h want 00000038", epc); end
    checks++; if (dec_valid !== 1'b0)    begin errors++; $display("FAIL irq_flush: got valid=%b want 0", dec_valid); end
    checks++; if (kernel_mode !== 1'b1)  begin errors++; $display("FAIL irq_kernel: got %b want 1", kernel_mode); end
    exp_q.push_back(exp_of(32'h8000_0004));
    exp_q.push_back(exp_of(32'h8000_0008));
    dec_ready = 1'b1;
    wait_empty("irq", 40);
    dec_ready = 1'b0;
    irq       = 1'b0;
  endtask

  task automatic test_kernel_irq();
    do_reset();
    irq       = 1'b1;
    dec_ready = 1'b1;
    exp_q.push_back(exp_of(32'h8000_0000));
    exp_q.push_back(exp_of(32'h8000_0004));
    exp_q.push_back(exp_of(32'h8000_0004));
    exp_q.push_back(exp_of(32'h8000_0008));
    repeat (4) tick();
    checks++; if (epc !== 32'd0) begin errors++; $display("FAIL kirq_ignored: got epc=%h want 0", epc); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (epc !== 32'h0000_0200) begin errors++; $display("FAIL kirq_epc: got %h want 00000200", epc); end
    checks++; if (kernel_mode !== 1'b1)  begin errors++; $display("FAIL kirq_kernel: got %b want 1", kernel_mode); end
    wait_empty("kernel_irq", 40);
    dec_ready = 1'b0;
    irq       = 1'b0;
  endtask

  task automatic test_exc_priority();
    do_reset();
    dec_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_1000;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h0000_1000) begin
      errors++;
      $display("FAIL exc_setup: got valid=%b pc=%h want valid=1 pc=00001000", dec_valid, dec_pc);
    end
    exp_q.push_back(exp_of(32'h0000_1000));
    exp_q.push_back(exp_of(32'h8000_0008));
    exp_q.push_back(exp_of(32'h8000_000C));
    exc_valid       = 1'b1;
    exc_pc          = 32'h0000_0024;
    irq             = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    tick();
    exc_valid      = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (epc !== 32'h0000_0024) begin errors++; $display("FAIL exc_epc: got %h want 00000024", epc); end
    checks++; if (kernel_mode !== 1'b1)  begin errors++; $display("FAIL exc_kernel: got %b want 1", kernel_mode); end
    wait_empty("exc", 40);
    dec_ready = 1'b0;
    irq       = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    dec_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h7FFF_FFFF;
    exp_q.push_back(exp_of(32'h7FFF_FFFC));
    exp_q.push_back(exp_of(32'h0000_0000));
    exp_q.push_back(exp_of(32'h0000_0004));
    tick();
    redirect_valid = 1'b0;
    wait_empty("wrap", 40);
    dec_ready = 1'b0;
    checks++; if (kernel_mode !== 1'b0) begin errors++; $display("FAIL wrap_kernel: got %b want 0", kernel_mode); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    mem_rand = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_of(32'h8000_0000 + 32'(4 * i)));
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      dec_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    dec_ready = 1'b0;
    wait_empty("back_to_back", 1);
    mem_rand = 1'b0;
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    base_cyc        = 0;
    base_ack        = 0;
    mem_lat         = 1;
    mem_rand        = 1'b0;
    reset           = 1'b0;
    dec_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    irq             = 1'b0;
    exc_valid       = 1'b0;
    exc_pc          = 32'd0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_irq_epc();
    test_kernel_irq();
    test_exc_priority();
    test_wrap();
    test_back_to_back();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
